// File: rtl/rpi_sample_fifo_irq_pkg.sv
// Shared constants and state encodings for the Pi-facing sample FIFO.
`timescale 1ns/1ps
package rpi_sample_fifo_irq_pkg;

  localparam int SAMPLE_WIDTH          = 32;
  localparam int DEFAULT_DEPTH_LOG2    = 6;
  localparam int DEFAULT_IRQ_THRESHOLD = 32;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_RELEASE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/rpi_sample_fifo_irq_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input plus rising-edge detect.
`timescale 1ns/1ps
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // History resets to RESET_VAL so a line held at that level through reset is not an edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out   = sync_q[STAGES-1];
  assign rise_pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/rpi_sample_fifo_irq.sv
// Sample FIFO between the I2S deserialiser and the Pi strobe-read port,
// with a level-triggered interrupt request that holds until the buffer drains.
`timescale 1ns/1ps
module rpi_sample_fifo_irq
  import rpi_sample_fifo_irq_pkg::*;
#(
  parameter int DATA_WIDTH    = SAMPLE_WIDTH,
  parameter int DEPTH_LOG2    = DEFAULT_DEPTH_LOG2,
  parameter int IRQ_THRESHOLD = DEFAULT_IRQ_THRESHOLD,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  rpi_rd_strobe,
  output logic [DATA_WIDTH-1:0] rpi_data,
  output logic                  rpi_data_valid,
  output logic                  interrupt_enable,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH   = 2**DEPTH_LOG2;
  localparam int LEVEL_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rpi_data_q;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rpi_data_valid_q, rpi_data_valid_d;

  irq_state_e            state_q;
  logic                  irq_q;

  logic strobe_sync, strobe_rise, pop_pulse;
  logic full, empty, push_ok, pop_ok;

  sync_edge_detect #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_strobe_sync (
    .clk_in     (clk_in),
    .reset      (reset),
    .async_in   (rpi_rd_strobe),
    .sync_out   (strobe_sync),
    .rise_pulse (strobe_rise)
  );

  assign pop_pulse = strobe_rise & strobe_sync;

  always_comb begin
    full  = (level_q == LEVEL_W'(DEPTH));
    empty = (level_q == '0);
    pop_ok = pop_pulse && !empty;
    // A simultaneous pop frees the slot, so a push at full still lands.
    push_ok = sample_valid && (!full || pop_ok);

    wr_ptr_d         = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d         = pop_ok  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    rpi_data_valid_d = rpi_data_valid_q | pop_ok;
    overflow_d       = overflow_q  | (sample_valid && !push_ok);
    underflow_d      = underflow_q | (pop_pulse && empty);

    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_q          <= '0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      rpi_data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      level_q          <= level_d;
      overflow_q       <= overflow_d;
      underflow_q      <= underflow_d;
      rpi_data_valid_q <= rpi_data_valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= sample_in;
    end
  end

  // Read-old-data when push and pop hit the same address at full.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rpi_data_q <= '0;
    end else if (pop_ok) begin
      rpi_data_q <= mem[rd_ptr_q];
    end
  end

  // RELEASE forces at least one low cycle so the downstream clock counter clears.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (level_q >= LEVEL_W'(IRQ_THRESHOLD)) begin
            state_q <= IRQ_ASSERT;
            irq_q   <= 1'b1;
          end
        end
        IRQ_ASSERT: begin
          if (level_q == '0) begin
            state_q <= IRQ_RELEASE;
            irq_q   <= 1'b0;
          end
        end
        IRQ_RELEASE: begin
          state_q <= IRQ_IDLE;
          irq_q   <= 1'b0;
        end
        default: begin
          state_q <= IRQ_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rpi_data         = rpi_data_q;
  assign rpi_data_valid   = rpi_data_valid_q;
  assign interrupt_enable = irq_q;
  assign fifo_level       = level_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: tb/tb_rpi_sample_fifo_irq.sv
// Scoreboard bench for rpi_sample_fifo_irq: pushes are queued, pops compare against the queue head.
`timescale 1ns/1ps
module tb_rpi_sample_fifo_irq;

  localparam int DW    = 32;
  localparam int DL2   = 6;
  localparam int DEPTH = 64;
  localparam int TH    = 32;
  localparam int SS    = 2;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          rpi_rd_strobe = 1'b0;
  logic [DW-1:0] rpi_data;
  logic          rpi_data_valid;
  logic          interrupt_enable;
  logic [DL2:0]  fifo_level;
  logic          overflow;
  logic          underflow;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] next_word = 32'hA500_0000;
  logic [DW-1:0] last_data = '0;

  rpi_sample_fifo_irq #(
    .DATA_WIDTH    (DW),
    .DEPTH_LOG2    (DL2),
    .IRQ_THRESHOLD (TH),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk_in           (clk_in),
    .reset            (reset),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .rpi_rd_strobe    (rpi_rd_strobe),
    .rpi_data         (rpi_data),
    .rpi_data_valid   (rpi_data_valid),
    .interrupt_enable (interrupt_enable),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  always #10 clk_in = ~clk_in;

  // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
  task automatic push_word();
    sample_in    = next_word;
    sample_valid = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(next_word);
    $display("push %h (model size %0d)", next_word, sb.size());
    next_word = next_word + 1;
    @(negedge clk_in);
    sample_valid = 1'b0;
  endtask

  task automatic pop_word(input string tag);
    logic [DW-1:0] exp;
    exp = (sb.size() == 0) ? last_data : sb.pop_front();
    rpi_rd_strobe = 1'b1;
    repeat (SS + 2) @(negedge clk_in);
    checks++;
    if (rpi_data !== exp) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", tag, rpi_data, exp);
    end else begin
      $display("pop %s data %h", tag, rpi_data);
    end
    last_data = exp;
    rpi_rd_strobe = 1'b0;
    repeat (SS + 1) @(negedge clk_in);
  endtask

  // Times the push so it lands on the same clock as the synchronised pop pulse.
  task automatic push_pop(input string tag);
    logic [DW-1:0] exp;
    exp = (sb.size() == 0) ? last_data : sb.pop_front();
    rpi_rd_strobe = 1'b1;
    repeat (SS) @(negedge clk_in);
    sample_in    = next_word;
    sample_valid = 1'b1;
    sb.push_back(next_word);
    next_word = next_word + 1;
    @(negedge clk_in);
    sample_valid = 1'b0;
    checks++;
    if (rpi_data !== exp) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", tag, rpi_data, exp);
    end else begin
      $display("push+pop %s data %h", tag, rpi_data);
    end
    last_data = exp;
    rpi_rd_strobe = 1'b0;
    repeat (SS + 1) @(negedge clk_in);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rpi_rd_strobe = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    repeat (5) @(negedge clk_in);
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (rpi_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", rpi_data); end
    checks++; if (rpi_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rpi_data_valid); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (interrupt_enable !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", interrupt_enable); end
    rpi_rd_strobe = 1'b0;
    repeat (SS + 1) @(negedge clk_in);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_strobe_release: underflow got %b expected 0", underflow); end
    $display("reset test done");
  endtask

  task automatic test_irq_threshold();
    repeat (TH - 1) push_word();
    checks++; if (fifo_level !== 7'(TH - 1)) begin errors++; $display("FAIL thr_level31: got %0d expected %0d", fifo_level, TH - 1); end
    checks++; if (interrupt_enable !== 1'b0) begin errors++; $display("FAIL thr_irq31: got %b expected 0", interrupt_enable); end
    push_word();
    checks++; if (fifo_level !== 7'(TH)) begin errors++; $display("FAIL thr_level32: got %0d expected %0d", fifo_level, TH); end
    checks++; if (interrupt_enable !== 1'b0) begin errors++; $display("FAIL thr_irq_same_cycle: got %b expected 0", interrupt_enable); end
    @(negedge clk_in);
    checks++; if (interrupt_enable !== 1'b1) begin errors++; $display("FAIL thr_irq_next_cycle: got %b expected 1", interrupt_enable); end
  endtask

  task automatic test_drain();
    logic exp_irq;
    for (int i = 0; i < TH; i++) begin
      pop_word("drain");
      exp_irq = (sb.size() != 0);
      checks++;
      if (interrupt_enable !== exp_irq) begin
        errors++;
        $display("FAIL drain_irq pop %0d: got %b expected %b", i, interrupt_enable, exp_irq);
      end
    end
    checks++; if (rpi_data_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b expected 1", rpi_data_valid); end
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_overflow();
    repeat (70) push_word();
    @(negedge clk_in);
    checks++; if (fifo_level !== 7'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d expected %0d", fifo_level, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (interrupt_enable !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b expected 1", interrupt_enable); end
    for (int i = 0; i < DEPTH; i++) pop_word("ovf_drain");
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL ovf_drain_level: got %0d expected 0", fifo_level); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_no_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_underflow_and_simul();
    logic [DW-1:0] held;
    held = last_data;
    pop_word("empty_pop");
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b expected 1", underflow); end
    checks++; if (rpi_data !== held) begin errors++; $display("FAIL udf_data_hold: got %h expected %h", rpi_data, held); end
    push_pop("at_empty");
    checks++; if (fifo_level !== 7'd1) begin errors++; $display("FAIL simul_empty_level: got %0d expected 1", fifo_level); end
    repeat (4) push_word();
    checks++; if (fifo_level !== 7'd5) begin errors++; $display("FAIL simul_pre_level: got %0d expected 5", fifo_level); end
    push_pop("at_level5");
    checks++; if (fifo_level !== 7'd5) begin errors++; $display("FAIL simul_level5: got %0d expected 5", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sticky_overflow: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_midop();
    repeat (35) push_word();
    @(negedge clk_in);
    checks++; if (fifo_level !== 7'd40) begin errors++; $display("FAIL mid_level40: got %0d expected 40", fifo_level); end
    checks++; if (interrupt_enable !== 1'b1) begin errors++; $display("FAIL mid_irq_before: got %b expected 1", interrupt_enable); end
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    checks++; if (fifo_level !== 7'd0) begin errors++; $display("FAIL mid_level_after: got %0d expected 0", fifo_level); end
    checks++; if (interrupt_enable !== 1'b0) begin errors++; $display("FAIL mid_irq_after: got %b expected 0", interrupt_enable); end
    checks++; if (rpi_data !== 32'd0) begin errors++; $display("FAIL mid_data_after: got %h expected 0", rpi_data); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_flags_after: got ovf=%b udf=%b expected 0 0", overflow, underflow); end
    sb.delete();
    last_data = '0;
    repeat (SS + 1) @(negedge clk_in);
    push_word();
    push_word();
    pop_word("after_reset");
    checks++; if (fifo_level !== 7'd1) begin errors++; $display("FAIL mid_level_final: got %0d expected 1", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_irq_threshold();
    test_drain();
    test_overflow();
    test_underflow_and_simul();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
